// File: rtl/rv_key_periph.sv
// rv_key_periph: memory-mapped push-button block on the core data bus.
// Synchronises and debounces NKEYS raw buttons, latches press events in a
// write-1-to-clear register and raises a registered level interrupt.
//
// Bus handshake: a request is accepted on every clock edge where data_req_i=1
// (there is no ready and no backpressure). An accepted read (data_we_i=0)
// returns data_rvalid_o=1 for exactly one cycle, on the cycle after the
// request, with data_rdata_o holding the register value sampled before the
// request edge. Writes give no response. data_rdata_o keeps its last value
// while data_rvalid_o=0.
module rv_key_periph #(
   parameter int NKEYS           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int KEY_ACTIVE_LOW  = 1,
   parameter int XLEN            = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              data_req_i,
   input  logic              data_we_i,
   input  logic [XLEN/8-1:0] data_be_i,
   input  logic [XLEN-1:0]   data_addr_i,
   input  logic [XLEN-1:0]   data_wdata_i,
   output logic              data_rvalid_o,
   output logic [XLEN-1:0]   data_rdata_o,
   input  logic [NKEYS-1:0]  key_i,
   output logic              irq_o
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
   // raw level of a key that is not pressed
   localparam logic [NKEYS-1:0] RELEASED = (KEY_ACTIVE_LOW != 0) ? '1 : '0;

   logic [NKEYS-1:0] sync1_q, sync2_q;
   logic [NKEYS-1:0] key_lvl;
   logic [NKEYS-1:0] state_q, state_nxt;
   logic [NKEYS-1:0] evt_q, evt_nxt, evt_clr;
   logic [NKEYS-1:0] irq_en_q;
   logic [NKEYS-1:0] rd_val;
   logic [CW-1:0]    cnt_q   [NKEYS];
   logic [CW-1:0]    cnt_nxt [NKEYS];
   logic             wr_en;
   logic             rd_en;

   // bus fields this block never looks at
   logic unused_bus;
   assign unused_bus = &{1'b0, data_be_i[XLEN/8-1:1], data_addr_i[XLEN-1:4],
                         data_addr_i[1:0], data_wdata_i[XLEN-1:NKEYS]};

   assign wr_en = data_req_i & data_we_i & data_be_i[0];
   assign rd_en = data_req_i & ~data_we_i;

   // polarity normalised after the second synchroniser flop: 1 = pressed
   assign key_lvl = (KEY_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

   // two-flop synchroniser per key, reset to the released level
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= RELEASED;
         sync2_q <= RELEASED;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
      end
   end

   // debounce: a level must disagree with STATE for DEBOUNCE_CYCLES cycles
   always_comb begin
      state_nxt = state_q;
      for (int k = 0; k < NKEYS; k++) begin
         cnt_nxt[k] = '0;
         if (key_lvl[k] != state_q[k]) begin
            if (cnt_q[k] == CNT_MAX) begin
               state_nxt[k] = key_lvl[k];
            end else begin
               cnt_nxt[k] = cnt_q[k] + 1'b1;
            end
         end
      end
   end

   // W1C clear mask and event update; a new press wins over a same-cycle clear
   always_comb begin
      evt_clr = '0;
      if (wr_en && data_addr_i[3:2] == 2'd1) begin
         evt_clr = data_wdata_i[NKEYS-1:0];
      end
      evt_nxt = (evt_q & ~evt_clr) | (state_nxt & ~state_q);
   end

   // register read mux; unmapped offset and upper bits read as zero
   always_comb begin
      rd_val = '0;
      case (data_addr_i[3:2])
         2'd0:    rd_val = state_q;
         2'd1:    rd_val = evt_q;
         2'd2:    rd_val = irq_en_q;
         default: rd_val = '0;
      endcase
   end

   // debounce counters, STATE, EVENT and IRQ_EN registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= '0;
         evt_q    <= '0;
         irq_en_q <= '0;
         for (int k = 0; k < NKEYS; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         state_q <= state_nxt;
         evt_q   <= evt_nxt;
         for (int k = 0; k < NKEYS; k++) begin
            cnt_q[k] <= cnt_nxt[k];
         end
         if (wr_en && data_addr_i[3:2] == 2'd2) begin
            irq_en_q <= data_wdata_i[NKEYS-1:0];
         end
      end
   end

   // read response one cycle after the request, and registered interrupt
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_rvalid_o <= 1'b0;
         data_rdata_o  <= '0;
         irq_o         <= 1'b0;
      end else begin
         data_rvalid_o <= rd_en;
         if (rd_en) begin
            data_rdata_o <= {{(XLEN-NKEYS){1'b0}}, rd_val};
         end
         irq_o <= |(evt_q & irq_en_q);
      end
   end

endmodule

// File: tb/tb_rv_key_periph.sv
// Bench for rv_key_periph with NKEYS=4, DEBOUNCE_CYCLES=8, active-low keys.
// All stimulus changes on the falling edge; "read i" issued at falling edge i
// after a key change is sampled at rising edge i+1 and returns the register
// value after i rising edges. A key change settles into STATE after 10 edges.
module tb_rv_key_periph;

   logic        clk;
   logic        rst;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;
   logic [3:0]  key;
   logic        irq;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];

   rv_key_periph #(
      .NKEYS(4), .DEBOUNCE_CYCLES(8), .KEY_ACTIVE_LOW(1), .XLEN(32)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .data_req_i(req), .data_we_i(we), .data_be_i(be),
      .data_addr_i(addr), .data_wdata_i(wdata),
      .data_rvalid_o(rvalid), .data_rdata_o(rdata),
      .key_i(key), .irq_o(irq)
   );

   // clock and power-on reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // driver tasks: called on a falling edge, return on the next falling edge
   task automatic bus_read(input logic [31:0] a, input logic [31:0] e);
      req = 1'b1; we = 1'b0; be = 4'hF; addr = a;
      exp_q.push_back(e);
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      req = 1'b1; we = 1'b1; be = b; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // monitor: every response must match the oldest expectation, on time
   always @(posedge clk) begin : monitor
      logic [31:0] e;
      #1;
      if (rvalid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: got rvalid=1 data=0x%0h expected rvalid=0 at %0t", rdata, $time);
         end else begin
            e = exp_q.pop_front();
            check("rd_data", rdata, e);
         end
      end else if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         total++;
         bad++;
         $display("FAIL rd_missing: got rvalid=0 expected rvalid=1 data=0x%0h at %0t", e, $time);
      end
   end

   // watchdog
   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
      key = 4'b1110;

      // 1. reset with key 0 held; STATE appears 10 edges after release
      idle(2);
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i <= 10; i++) bus_read(32'h0, (i >= 10) ? 32'h1 : 32'h0);
      key = 4'b1111;
      idle(12);
      bus_write(32'h4, 32'hF, 4'h1);
      bus_read(32'h4, 32'h0);
      bus_read(32'h0, 32'h0);
      bus_write(32'h8, 32'h2, 4'h1);

      // 2. 5-cycle glitch on key 1 never reaches STATE or EVENT
      key[1] = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i == 5) key[1] = 1'b1;
         check("t2_irq", {31'd0, irq}, 32'd0);
         bus_read(32'h0, 32'h0);
      end
      bus_read(32'h4, 32'h0);

      // 3. clean press on key 2 with IRQ_EN=0x4
      bus_write(32'h8, 32'h4, 4'h1);
      key[2] = 1'b0;
      for (int i = 0; i < 14; i++) begin
         check("t3_irq", {31'd0, irq}, (i >= 11) ? 32'd1 : 32'd0);
         bus_read((i % 2 == 0) ? 32'h4 : 32'h0, (i >= 10) ? 32'h4 : 32'h0);
      end
      key[2] = 1'b1;
      idle(14);
      bus_read(32'h4, 32'h4);
      bus_read(32'h0, 32'h0);
      check("t3_irq_hold", {31'd0, irq}, 32'd1);

      // 4. W1C, byte-enable gating, set beats same-cycle clear
      key = 4'b1110;
      idle(12);
      bus_read(32'h4, 32'h5);
      bus_write(32'h4, 32'h1, 4'h1);
      bus_read(32'h4, 32'h4);
      bus_write(32'h4, 32'h4, 4'h0);
      bus_read(32'h4, 32'h4);
      key = 4'b1111;
      idle(12);
      key = 4'b1110;
      idle(9);
      bus_write(32'h4, 32'h1, 4'h1);
      bus_read(32'h4, 32'h5);
      check("t4_irq_set", {31'd0, irq}, 32'd1);
      bus_write(32'h4, 32'h4, 4'h1);
      check("t4_irq_lag", {31'd0, irq}, 32'd1);
      idle(1);
      check("t4_irq_clr", {31'd0, irq}, 32'd0);

      // 5. back-to-back reads, ignored writes, masked upper bits
      bus_read(32'h0, 32'h1);
      bus_read(32'h4, 32'h1);
      bus_read(32'h8, 32'h4);
      bus_read(32'hC, 32'h0);
      bus_write(32'hC, 32'hFFFF_FFFF, 4'h1);
      bus_write(32'h0, 32'h0, 4'h1);
      bus_write(32'h8, 32'hFFFF_FFFF, 4'hF);
      bus_read(32'h9, 32'hF);
      bus_read(32'h0, 32'h1);
      bus_read(32'hC, 32'h0);
      bus_read(32'h4, 32'h1);
      check("t5_irq_unmask", {31'd0, irq}, 32'd1);

      // 6. reset during a pending read and a half-debounced press
      key = 4'b1111;
      idle(12);
      bus_write(32'h4, 32'hF, 4'h1);
      key = 4'b1110;
      idle(5);
      req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0;
      rst = 1'b1;
      @(negedge clk);
      req = 1'b0;
      check("t6_rvalid", {31'd0, rvalid}, 32'd0);
      check("t6_rdata", rdata, 32'd0);
      check("t6_irq", {31'd0, irq}, 32'd0);
      idle(1);
      rst = 1'b0;
      for (int i = 0; i <= 10; i++) bus_read(32'h4, (i >= 10) ? 32'h1 : 32'h0);
      check("t6_irq_after", {31'd0, irq}, 32'd0);

      idle(3);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
